pl_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined MIPS core; successor to the fixed E/M-only decode control.

---
 rtl/pl_hazard_pkg.sv | 19 +
 rtl/pl_hazard_if.sv | 53 +++++
 rtl/pl_stage_track.sv | 28 ++
 rtl/pl_hazard_unit.sv | 133 +++++++++++++
 tb/tb_pl_hazard_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pl_hazard_pkg.sv
// rtl/pl_hazard_pkg.sv - shared types and helpers for the pipeline hazard/forwarding controller
package pl_hazard_pkg;

  // Stage records carry a fixed-width destination so the record type is parameter-independent.
  localparam int DEST_MAX_W  = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEST_MAX_W-1:0] dest;
    logic                  wreg;
    logic                  load;
  } stage_rec_t;

  function automatic int fwd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pl_hazard_if.sv
// rtl/pl_hazard_if.sv - ID-stage request / hazard-response bundle
// Optional perf counter outputs present when PL_HAZARD_PERF_EN is defined.
interface pl_hazard_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
) ();
  import pl_hazard_pkg::*;

  localparam int FW = fwd_width(DEPTH);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic [REG_W-1:0] id_dest;
  logic             id_load;
  logic             id_multi;
  logic             id_redirect;

  logic [FW-1:0]    fwda;
  logic [FW-1:0]    fwdb;
  logic             stall;
  logic             issue;
  logic             flush_if;
  logic             md_busy;
  logic             md_done;
  logic [REG_W-1:0] md_dest;
`ifdef PL_HAZARD_PERF_EN
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_flush_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wreg, id_dest, id_load, id_multi, id_redirect,
    input  fwda, fwdb, stall, issue, flush_if, md_busy, md_done, md_dest
`ifdef PL_HAZARD_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wreg, id_dest, id_load, id_multi, id_redirect,
    output fwda, fwdb, stall, issue, flush_if, md_busy, md_done, md_dest
`ifdef PL_HAZARD_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/pl_stage_track.sv
// rtl/pl_stage_track.sv - DEPTH-entry destination record shift register
// Entry 0 is the stage right after ID; a bubble is inserted when push is low.
module pl_stage_track
  import pl_hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  stage_rec_t in_rec,
  output stage_rec_t recs [DEPTH]
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        recs[k] <= '0;
      end
    end else begin
      recs[0] <= push ? in_rec : '0;
      for (int k = 1; k < DEPTH; k++) begin
        recs[k] <= recs[k-1];
      end
    end
  end

endmodule

// File: rtl/pl_hazard_unit.sv
// rtl/pl_hazard_unit.sv - hazard/forwarding controller with multi-cycle unit scoreboard
// Defining PL_HAZARD_PERF_EN adds saturating stall/flush event counters.
module pl_hazard_unit
  import pl_hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT     = 4
) (
  input logic        clock,
  input logic        reset,
  pl_hazard_if.slave hz
);

  localparam int FW = fwd_width(DEPTH);
  localparam int CW = $clog2(MD_LAT + 1);

  stage_rec_t       recs [DEPTH];
  stage_rec_t       in_rec;
  logic             push;

  logic             hit_a, hit_b;
  logic             rdy_a, rdy_b;
  logic [FW-1:0]    sel_a, sel_b;

  logic [CW-1:0]    md_cnt;
  logic [REG_W-1:0] md_dest_q;
  logic             md_busy;
  logic             md_raw, md_waw, md_hazard;
  logic             stall, issue;

  function automatic logic rec_match(input stage_rec_t rec, input logic [REG_W-1:0] r);
    return rec.valid & rec.wreg & (rec.dest == DEST_MAX_W'(r)) & (r != '0);
  endfunction

  // Scan oldest to youngest so the nearest matching stage overwrites older ones.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    sel_a = FW'(FWD_REGFILE);
    sel_b = FW'(FWD_REGFILE);
    for (int k = DEPTH; k >= 1; k--) begin
      if (rec_match(recs[k-1], hz.id_rs)) begin
        hit_a = 1'b1;
        sel_a = FW'(k);
        rdy_a = ~recs[k-1].load | (k >= LOAD_STAGE);
      end
      if (rec_match(recs[k-1], hz.id_rt)) begin
        hit_b = 1'b1;
        sel_b = FW'(k);
        rdy_b = ~recs[k-1].load | (k >= LOAD_STAGE);
      end
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign md_raw    = (hz.id_use_rs & (hz.id_rs == md_dest_q) & (hz.id_rs != '0)) |
                     (hz.id_use_rt & (hz.id_rt == md_dest_q) & (hz.id_rt != '0));
  assign md_waw    = hz.id_wreg & (hz.id_dest == md_dest_q);
  assign md_hazard = md_busy & (hz.id_multi | md_raw | md_waw);

  assign stall = hz.id_valid & ((hz.id_use_rs & hit_a & ~rdy_a) |
                                (hz.id_use_rt & hit_b & ~rdy_b) |
                                md_hazard);
  assign issue = hz.id_valid & ~stall;

  assign hz.stall    = stall;
  assign hz.issue    = issue;
  assign hz.flush_if = issue & hz.id_redirect;
  assign hz.fwda     = (hz.id_valid & hz.id_use_rs & hit_a) ? sel_a : FW'(FWD_REGFILE);
  assign hz.fwdb     = (hz.id_valid & hz.id_use_rt & hit_b) ? sel_b : FW'(FWD_REGFILE);
  assign hz.md_busy  = md_busy;
  assign hz.md_done  = (md_cnt == CW'(1));
  assign hz.md_dest  = md_dest_q;

  // Multi-cycle ops bypass the stage records; their writeback is tracked by the scoreboard.
  assign push = issue & ~hz.id_multi;
  always_comb begin
    in_rec       = '0;
    in_rec.valid = 1'b1;
    in_rec.dest  = DEST_MAX_W'(hz.id_dest);
    in_rec.wreg  = hz.id_wreg;
    in_rec.load  = hz.id_load;
  end

  pl_stage_track #(
    .DEPTH (DEPTH)
  ) u_track (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .in_rec (in_rec),
    .recs   (recs)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt    <= '0;
      md_dest_q <= '0;
    end else if (issue & hz.id_multi) begin
      md_cnt    <= CW'(MD_LAT);
      md_dest_q <= hz.id_dest;
    end else if (md_busy) begin
      md_cnt    <= md_cnt - CW'(1);
    end
  end

`ifdef PL_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (hz.flush_if && perf_flush_q != '1) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pl_hazard_unit.sv
// tb/tb_pl_hazard_unit.sv - directed self-checking bench for pl_hazard_unit
module tb_pl_hazard_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  pl_hazard_if #(.REG_W(5), .DEPTH(3)) hz ();

  pl_hazard_unit #(
    .REG_W      (5),
    .DEPTH      (3),
    .LOAD_STAGE (2),
    .MD_LAT     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] dst, input logic ld, input logic mul,
                       input logic rdr);
    hz.id_valid    = v;
    hz.id_rs       = rs;
    hz.id_rt       = rt;
    hz.id_use_rs   = urs;
    hz.id_use_rt   = urt;
    hz.id_wreg     = wr;
    hz.id_dest     = dst;
    hz.id_load     = ld;
    hz.id_multi    = mul;
    hz.id_redirect = rdr;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_stall", hz.stall, 0);
    chk("rst_busy", hz.md_busy, 0);
    chk("rst_done", hz.md_done, 0);
    chk("rst_fwda", hz.fwda, 0);
    chk("rst_flush", hz.flush_if, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // add $3 then two readers at distances 1 and 2
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
    chk("t1_issue", hz.issue, 1);
    chk("t1_fwda0", hz.fwda, 0);
    tick();
    drive(1, 3, 2, 1, 1, 1, 4, 0, 0, 0);
    chk("t1_fwda1", hz.fwda, 1);
    chk("t1_stall", hz.stall, 0);
    tick();
    drive(1, 3, 4, 1, 1, 0, 0, 0, 0, 0);
    chk("t1_fwda2", hz.fwda, 2);
    chk("t1_fwdb1", hz.fwdb, 1);
    tick();
    idle(); tick(); tick(); tick();

    // lw $5 then immediate reader with a taken redirect
    drive(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);
    tick();
    drive(0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_inv_stall", hz.stall, 0);
    chk("t2_inv_issue", hz.issue, 0);
    chk("t2_inv_fwda", hz.fwda, 0);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("t2_stall", hz.stall, 1);
    chk("t2_issue", hz.issue, 0);
    chk("t2_flush_stalled", hz.flush_if, 0);
    tick();
    chk("t2_stall_clear", hz.stall, 0);
    chk("t2_fwda", hz.fwda, 2);
    chk("t2_flush", hz.flush_if, 1);
    tick();
    idle(); tick(); tick(); tick();

    // $3 in stages 1 and 2, then $0 pending as a load
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(1, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("t3_fwda_near", hz.fwda, 1);
    chk("t3_fwdb_zero", hz.fwdb, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("t3_r0_stall", hz.stall, 0);
    chk("t3_r0_fwda", hz.fwda, 0);
    tick();
    idle(); tick(); tick(); tick();

    // taken branch with no hazard
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1);
    chk("t5_flush", hz.flush_if, 1);
    chk("t5_stall", hz.stall, 0);
    tick();

    // mult $8 followed by a reader of $8
    drive(1, 1, 2, 1, 1, 1, 8, 0, 1, 0);
    chk("t4_mul_issue", hz.issue, 1);
    tick();
    drive(1, 8, 0, 1, 0, 1, 11, 0, 0, 0);
    chk("t4_busy", hz.md_busy, 1);
    chk("t4_md_dest", hz.md_dest, 8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall", hz.stall, 1);
      chk("t4_done", hz.md_done, (i == 3) ? 1 : 0);
      tick();
    end
    chk("t4_rel_stall", hz.stall, 0);
    chk("t4_rel_issue", hz.issue, 1);
    chk("t4_rel_fwda", hz.fwda, 0);
    chk("t4_rel_busy", hz.md_busy, 0);
    tick();

    // mult $9, WAW check, then back-to-back mult $10
    drive(1, 1, 2, 1, 1, 1, 9, 0, 1, 0);
    chk("t4b_issue", hz.issue, 1);
    tick();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("t4b_waw_stall", hz.stall, 1);
    drive(1, 1, 2, 1, 1, 1, 10, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4b_stall", hz.stall, 1);
      chk("t4b_done", hz.md_done, (i == 3) ? 1 : 0);
      tick();
    end
    chk("t4b_issue2", hz.issue, 1);
    tick();
    chk("t4b_md_dest", hz.md_dest, 10);

    // reset in the middle of the multi op
    drive(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t6_pre_stall", hz.stall, 1);
    chk("t6_pre_busy", hz.md_busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_busy", hz.md_busy, 0);
    chk("t6_stall", hz.stall, 0);
    chk("t6_issue", hz.issue, 1);
    @(negedge clock);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_done", hz.md_done, 0);
      chk("t6_no_busy", hz.md_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
